cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port miss_detected  input  1  the cache reports Miss on a valid access this cycle.
REQ-005 SHALL have port miss_address  input  16  byte address of the missing access.
REQ-006 SHALL have port memory_data  input  16  word returned by main memory.
REQ-007 SHALL have port memory_data_valid  input  1  memory_data is valid this cycle; returns arrive in request order.
REQ-008 SHALL have port fsm_busy  output  1  fill in progress; the pipeline stalls.
REQ-009 SHALL have port memory_read_en  output  1  issue one word read this cycle.
REQ-010 SHALL have port memory_address  output  16  address of the issued read.
REQ-011 SHALL have port write_data_array  output  1  write cache_data into the cache data array.
REQ-012 SHALL have port write_tag_array  output  1  write the metadata (valid=1, tag) for the filled block.
REQ-013 SHALL have port cache_address  output  16  address presented to the cache during a fill write.
REQ-014 SHALL have port cache_data  output  16  word written into the data array.

Function
REQ-015 SHALL implement states IDLE, FILL and META.
REQ-016 In IDLE, miss_detected=1 SHALL latch base = {miss_address[15:4], 4'b0000}, clear both counters, and enter FILL on the next edge.
REQ-017 fsm_busy SHALL be 1 in FILL and META, and 0 in IDLE.
REQ-018 In FILL, memory_read_en SHALL be 1 while issue_count<8, with memory_address = base + 2*issue_count; issue_count increments each such cycle (8 reads in 8 consecutive cycles).
REQ-019 In FILL, each memory_data_valid=1 cycle SHALL combinationally assert write_data_array=1, with cache_data = memory_data and cache_address = base + 2*recv_count; recv_count then increments.
REQ-020 A memory_data_valid that arrives in the same cycle as a read issue SHALL be handled independently; both counters may advance in one cycle.
REQ-021 When the 8th return (recv_count=7, valid=1) is written, the FSM SHALL enter META on the next edge.
REQ-022 In META, the FSM SHALL assert write_tag_array=1 for exactly one cycle with cache_address = base, then enter IDLE.
REQ-023 miss_detected SHALL be ignored in FILL and META.
REQ-024 memory_data_valid SHALL be ignored in IDLE and META.
REQ-025 Counters SHALL be 4 bits wide and saturate at 8; address arithmetic is 16-bit modulo.
REQ-026 A base of 16'hFFF0 SHALL fill 16'hFFF0..16'hFFFE with no carry outside the block.
REQ-027 Fill latency SHALL be (cycle of the 8th valid) + 1 (META) + 1 (back in IDLE), measured from the miss edge.
REQ-028 Outputs SHALL be 0 whenever their state or condition is not active.

Reset
REQ-029 While rst=1 at an edge, the FSM SHALL go to IDLE, clear base and both counters to 0, and drive all outputs to 0.
REQ-030 A reset in mid-fill SHALL abandon the fill with no META write; a miss_detected present during reset SHALL NOT be latched.

Structure
REQ-031 Package cache_pkg SHALL hold the state enum (IDLE, FILL, META), WORDS_PER_BLOCK=8 and BLOCK_OFFSET_BITS=4.
REQ-032 Sub-module word_counter (4-bit, saturating, with clear and enable) SHALL be instantiated twice, once for issue_count and once for recv_count.

Verification
REQ-033 Reset mid-FILL (3 words written) -> next cycle state is IDLE, all outputs 0, no write_tag_array.
REQ-034 miss_address=16'h1236, memory returning each word 2 cycles after its request -> reads at 0x1230..0x123E; writes of D0..D7 at 0x1230..0x123E; META asserts write_tag_array with cache_address=0x1230; fsm_busy low 12 cycles after the miss edge.
REQ-035 miss_address=16'hFFFA -> reads at 0xFFF0..0xFFFE, and no address outside that range is issued.
REQ-036 Returns stalled (valid=0) for 20 cycles after the 8 issues -> memory_read_en stays 0 after 8 issues; FSM remains in FILL with fsm_busy=1 until 8 valids arrive.
REQ-037 miss_detected held high through a whole fill with a different address -> the second miss is not latched; one additional fill starts only after IDLE is re-entered.
REQ-038 memory_data_valid pulses while in IDLE -> write_data_array stays 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block-fill controller.
// A block is 8 halfword-aligned 16-bit words, so its byte offset is 4 bits.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        META = 2'd2
    } fill_state_t;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;

    // Byte address of word idx inside the block at base (16-bit wrap).
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [3:0] idx);
        return base + {11'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/word_counter.sv
// 4-bit word counter with synchronous clear and enable.
// It stops at WORDS_PER_BLOCK so a stray enable can never run past the block.
module word_counter
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count
);

    localparam logic [3:0] SAT = 4'(WORDS_PER_BLOCK);

    // Count register: reset/clear to zero, saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (en && (count < SAT)) begin
            count <= count + 4'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues 8 word reads for the missing block,
// writes each returned word into the data array, then writes the tag.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] cache_address,
    output logic [15:0] cache_data
);

    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [3:0] ALL_WORDS = 4'(WORDS_PER_BLOCK);

    fill_state_t state_r;
    fill_state_t state_next_s;
    logic [15:0] base_r;
    logic [3:0]  issue_count_s;
    logic [3:0]  recv_count_s;
    logic        start_s;
    logic        issue_en_s;
    logic        recv_en_s;

    word_counter u_issue_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_s),
        .en    (issue_en_s),
        .count (issue_count_s)
    );

    word_counter u_recv_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_s),
        .en    (recv_en_s),
        .count (recv_count_s)
    );

    // State and block base registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            base_r  <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                base_r <= {miss_address[15:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
            end else begin
                base_r <= base_r;
            end
        end
    end

    // Next-state and outputs; returns are written the same cycle they arrive.
    always_comb begin
        state_next_s     = state_r;
        start_s          = 1'b0;
        issue_en_s       = 1'b0;
        recv_en_s        = 1'b0;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        cache_address    = 16'h0000;
        cache_data       = 16'h0000;
        case (state_r)
            IDLE: begin
                if (miss_detected) begin
                    start_s      = 1'b1;
                    state_next_s = FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_count_s < ALL_WORDS) begin
                    memory_read_en = 1'b1;
                    memory_address = word_addr(base_r, issue_count_s);
                    issue_en_s     = 1'b1;
                end else begin
                    memory_read_en = 1'b0;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    cache_data       = memory_data;
                    cache_address    = word_addr(base_r, recv_count_s);
                    recv_en_s        = 1'b1;
                    state_next_s     = (recv_count_s == LAST_WORD) ? META : FILL;
                end else begin
                    state_next_s = FILL;
                end
            end
            META: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                cache_address   = base_r;
                state_next_s    = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a hand-computed vector table, directed corner
// sequences and randomized traffic, all checked against a transaction model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_address;
    logic [15:0] cache_data;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .cache_address     (cache_address),
        .cache_data        (cache_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, miss;
        logic [15:0] maddr, mdata;
        logic        mvalid;
        logic        busy, rd;
        logic [15:0] raddr;
        logic        wda, wta;
        logic [15:0] caddr, cdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: a fill is "in progress" with counts of words
    // requested and received; after the last word, one tag write is pending.
    bit          m_filling, m_tag_pending;
    int          m_base, m_issued, m_recv;

    int          cyc = 0;
    int          lat = 2;
    int          stall_pct = 0;
    bit          idle_noise = 1'b0;
    int          due_q[$];
    logic [15:0] rd_addrs[$];
    int          wta_seen = 0;
    int          wda_seen = 0;

    function automatic logic [51:0] dut_out();
        return {fsm_busy, memory_read_en, memory_address, write_data_array,
                write_tag_array, cache_address, cache_data};
    endfunction

    function automatic logic [51:0] model_out();
        logic busy, rd, wda, wta;
        logic [15:0] ra, ca, cd;
        busy = m_filling || m_tag_pending;
        rd   = m_filling && (m_issued < 8);
        ra   = rd ? 16'((m_base + 2 * m_issued) % 65536) : 16'h0000;
        wda  = m_filling && (memory_data_valid === 1'b1);
        wta  = m_tag_pending;
        if (wda) ca = 16'((m_base + 2 * m_recv) % 65536);
        else if (wta) ca = 16'(m_base);
        else ca = 16'h0000;
        cd   = wda ? memory_data : 16'h0000;
        return {busy, rd, ra, wda, wta, ca, cd};
    endfunction

    task automatic model_update();
        if (rst) begin
            m_filling = 1'b0; m_tag_pending = 1'b0;
            m_base = 0; m_issued = 0; m_recv = 0;
        end else if (m_filling) begin
            if (m_issued < 8) m_issued++;
            if (memory_data_valid) begin
                m_recv++;
                if (m_recv == 8) begin
                    m_filling = 1'b0;
                    m_tag_pending = 1'b1;
                end
            end
        end else if (m_tag_pending) begin
            m_tag_pending = 1'b0;
        end else if (miss_detected) begin
            m_base = (int'(miss_address) / 16) * 16;
            m_issued = 0;
            m_recv = 0;
            m_filling = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare at the falling edge, then advance model and DUT.
    task automatic step(input string name, input bit use_exp, input logic [51:0] exp_in);
        logic [51:0] exp;
        @(negedge clk);
        exp = use_exp ? exp_in : model_out();
        check(name, dut_out(), exp);
        if (memory_read_en === 1'b1) rd_addrs.push_back(memory_address);
        if (write_tag_array === 1'b1) wta_seen++;
        if (write_data_array === 1'b1) wda_seen++;
        @(posedge clk);
        model_update();
        #1;
        cyc++;
    endtask

    // Drive one cycle with an in-order memory that answers lat cycles after a read.
    task automatic auto_cycle(input bit miss, input logic [15:0] addr, input string name);
        rst = 1'b0;
        miss_detected = miss;
        miss_address = addr;
        memory_data = 16'($urandom);
        if (due_q.size() > 0 && due_q[0] <= cyc && $urandom_range(0, 99) >= stall_pct) begin
            memory_data_valid = 1'b1;
            void'(due_q.pop_front());
        end else if (idle_noise && !(m_filling || m_tag_pending)) begin
            memory_data_valid = 1'($urandom_range(0, 1));
        end else begin
            memory_data_valid = 1'b0;
        end
        if (m_filling && m_issued < 8) due_q.push_back(cyc + lat);
        step(name, 1'b0, 52'h0);
    endtask

    task automatic do_reset(input bit miss);
        rst = 1'b1;
        miss_detected = miss;
        miss_address = 16'h5A5A;
        memory_data_valid = 1'b0;
        memory_data = 16'h0000;
        step("reset", 1'b0, 52'h0);
        rst = 1'b0;
        miss_detected = 1'b0;
        due_q.delete();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (fsm_busy !== 1'b0 && n < budget) begin
            auto_cycle(1'b0, 16'h0000, name);
            n++;
        end
        checks++;
        if (fsm_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: fsm_busy=%b after %0d cycles, expected 0", name, fsm_busy, n);
        end
    endtask

    function automatic vec_t mk(input logic r, m, input logic [15:0] ma, md, input logic mv,
                                input logic b, rd, input logic [15:0] ra,
                                input logic wd, wt, input logic [15:0] ca, cd);
        vec_t v;
        v.rst = r; v.miss = m; v.maddr = ma; v.mdata = md; v.mvalid = mv;
        v.busy = b; v.rd = rd; v.raddr = ra; v.wda = wd; v.wta = wt; v.caddr = ca; v.cdata = cd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        // Miss at 0x1236, each word returns two cycles after its read.
        tbl[0]  = mk(1'b1, 1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[1]  = mk(1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[2]  = mk(1'b0, 1'b1, 16'h1236, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[3]  = mk(1'b0, 1'b1, 16'h9990, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[4]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1232, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 16'hA000, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h1230, 16'hA000);
        tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 16'hA001, 1'b1, 1'b1, 1'b1, 16'h1236, 1'b1, 1'b0, 16'h1232, 16'hA001);
        tbl[7]  = mk(1'b0, 1'b0, 16'h0000, 16'hA002, 1'b1, 1'b1, 1'b1, 16'h1238, 1'b1, 1'b0, 16'h1234, 16'hA002);
        tbl[8]  = mk(1'b0, 1'b0, 16'h0000, 16'hA003, 1'b1, 1'b1, 1'b1, 16'h123A, 1'b1, 1'b0, 16'h1236, 16'hA003);
        tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 16'hA004, 1'b1, 1'b1, 1'b1, 16'h123C, 1'b1, 1'b0, 16'h1238, 16'hA004);
        tbl[10] = mk(1'b0, 1'b0, 16'h0000, 16'hA005, 1'b1, 1'b1, 1'b1, 16'h123E, 1'b1, 1'b0, 16'h123A, 16'hA005);
        tbl[11] = mk(1'b0, 1'b0, 16'h0000, 16'hA006, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h123C, 16'hA006);
        tbl[12] = mk(1'b0, 1'b0, 16'h0000, 16'hA007, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h123E, 16'hA007);
        tbl[13] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1230, 16'h0000);
        tbl[14] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

        rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000;
        memory_data = 16'h0000; memory_data_valid = 1'b0;
        @(posedge clk);
        model_update();
        #1;

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; miss_detected = tbl[i].miss; miss_address = tbl[i].maddr;
            memory_data = tbl[i].mdata; memory_data_valid = tbl[i].mvalid;
            step($sformatf("table_row%0d", i), 1'b1,
                 {tbl[i].busy, tbl[i].rd, tbl[i].raddr, tbl[i].wda, tbl[i].wta, tbl[i].caddr, tbl[i].cdata});
        end

        // Reset after three words have been written abandons the fill.
        do_reset(1'b0);
        lat = 2; stall_pct = 0; wta_seen = 0; wda_seen = 0;
        auto_cycle(1'b1, 16'h4ABC, "midrst_miss");
        repeat (5) auto_cycle(1'b0, 16'h0000, "midrst_fill");
        check("midrst_three_writes", 52'(wda_seen), 52'd3);
        rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h7000; memory_data_valid = 1'b0;
        step("midrst_reset", 1'b0, 52'h0);
        rst = 1'b0; miss_detected = 1'b0; due_q.delete();
        step("midrst_after", 1'b1, 52'h0);
        repeat (4) auto_cycle(1'b0, 16'h0000, "midrst_idle");
        check("midrst_no_meta", 52'(wta_seen), 52'd0);

        // Block at the top of the address space stays inside the block.
        do_reset(1'b0);
        rd_addrs.delete(); lat = 1;
        auto_cycle(1'b1, 16'hFFFA, "wrap_miss");
        run_until_idle("wrap_fill", 40);
        check("wrap_count", 52'(rd_addrs.size()), 52'd8);
        for (int i = 0; i < rd_addrs.size(); i++)
            check($sformatf("wrap_addr%0d", i), 52'(rd_addrs[i]), 52'(16'hFFF0 + 16'(2 * i)));

        // Returns stalled for 20 cycles after the last read.
        do_reset(1'b0);
        rd_addrs.delete(); lat = 28;
        auto_cycle(1'b1, 16'h0C40, "stall_miss");
        repeat (27) auto_cycle(1'b0, 16'h0000, "stall_wait");
        check("stall_busy", 52'(fsm_busy), 52'd1);
        check("stall_reads", 52'(rd_addrs.size()), 52'd8);
        run_until_idle("stall_fill", 60);

        // Miss held high through a fill: the later address starts a second fill.
        do_reset(1'b0);
        rd_addrs.delete(); lat = 1;
        auto_cycle(1'b1, 16'h2004, "hold_miss");
        repeat (14) auto_cycle(1'b1, 16'h7777, "hold_fill");
        checks++;
        if (rd_addrs.size() < 9) begin
            errors++;
            $display("FAIL hold_reads: got %0d reads expected at least 9", rd_addrs.size());
        end else begin
            for (int i = 0; i < 8; i++)
                check($sformatf("hold_first%0d", i), 52'(rd_addrs[i]), 52'(16'h2000 + 16'(2 * i)));
            check("hold_second_base", 52'(rd_addrs[8]), 52'(16'h7770));
        end
        run_until_idle("hold_drain", 40);

        // Randomized traffic against the model.
        do_reset(1'b0);
        stall_pct = 25; idle_noise = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                auto_cycle(1'($urandom_range(0, 99) < 30), 16'($urandom), "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
